cmd_buff_mc: RTL and testbench
==============================

# cmd_buff_mc

Multi-channel command buffer: the parametrised successor of the single-queue AXI command FIFO. It accepts AXI-slave write beats tagged with the command region and steers each beat by address into one of CH_NUM per-channel FIFOs. Beats that hit a full channel are parked in one skid ("hang") register, which back-pressures the AXI side. Each channel drains to its own controller through a valid/ready port. Sits between the AXI slave write decoder and the per-engine controllers.

## Interface
- WDATA_WIDTH, 32: command word width; multiple of 8
- AWADDR_WIDTH, 32: AXI write address width
- CH_NUM, 4: channel count, power of two, ≥2
- ENT_NUM, 4: entries per channel FIFO, power of two, ≥2
- CH_SEL_LSB, 4: lowest address bit of the channel index field
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- axi_wr_vld  in  1  write beat valid
- axi_wr_rdy  out  1  buffer can take a beat this cycle
- axi_wr_addr  in  AWADDR_WIDTH  write address; channel = addr[CH_SEL_LSB +: log2(CH_NUM)]
- axi_wr_data  in  WDATA_WIDTH  command word
- axi_wr_strb  in  WDATA_WIDTH/8  byte strobes
- axi_wr_region  in  2  decoded region; only AXI_CMD_FIFO_REGION is taken
- ch_flush  in  CH_NUM  per-channel synchronous flush
- fifo_wr_done  out  1  one-cycle pulse: a beat was committed to a FIFO
- fifo_wr_ch  out  log2(CH_NUM)  channel of the committed beat, valid with fifo_wr_done
- fifo_wr_drop  out  1  one-cycle pulse: a parked beat was discarded by flush
- out_vld  out  CH_NUM  per-channel head valid
- out_data  out  CH_NUM*WDATA_WIDTH  per-channel head word; channel i at [i*W +: W]
- out_rdy  in  CH_NUM  per-channel pop
- ch_cnt  out  CH_NUM*(log2(ENT_NUM)+1)  per-channel occupancy

## Operation
- Qualified write: `wr_q = axi_wr_vld & axi_wr_rdy & (axi_wr_region == AXI_CMD_FIFO_REGION)`. Beats in other regions are ignored and produce no pulse.
- Strobe merge: bytes with strb=0 are stored as 8'h00. No read-modify-write.
- Direct path: if wr_q and the target channel is not full, push the beat into that channel this cycle.
- Park path: if wr_q and the target channel is full, load the hang register (channel, merged data) and set hang_vld.
- axi_wr_rdy = ~hang_vld.
- Retry: while hang_vld, the parked beat pushes on the first cycle its channel is not full. hang_vld clears in that same cycle, so axi_wr_rdy rises next cycle.
- Full means cnt == ENT_NUM, evaluated on registered state. A pop in cycle N frees space for a push in N+1 only, with no same-cycle bypass when full.
- When not full, push and pop in the same cycle are both legal and cnt is unchanged.
- out_vld[i] = (cnt[i] != 0). out_data[i] is the head entry and stays stable while out_vld & ~out_rdy.
- out_rdy with out_vld low is ignored.
- Flush of channel i clears its pointers and cnt in the next cycle; a push or pop to that channel in the flush cycle is discarded.
- If hang_vld targets channel i during flush, the parked beat is discarded, hang_vld clears, and fifo_wr_drop pulses next cycle. No fifo_wr_done is issued for that beat.
- Pointers wrap modulo ENT_NUM. cnt has one extra bit so full and empty are distinct.

## Timing
- Reset values: axi_wr_rdy=1, out_vld=0, out_data=0, ch_cnt=0, fifo_wr_done=0, fifo_wr_ch=0, fifo_wr_drop=0, hang_vld=0.
- Push in cycle N gives out_vld high and cnt incremented in N+1. fifo_wr_done and fifo_wr_ch are registered and also appear in N+1.
- Park: write accepted in N, axi_wr_rdy low from N+1. Space appears in N+k, the push happens in N+k, and fifo_wr_done is seen in N+k+1.
- Reset asserted mid-operation empties all FIFOs and the hang register immediately. No pulses are issued for lost beats.

## Structure
- cmd_buff_pkg holds the AXI_CMD_FIFO_REGION constant, a function returning the channel index from an address, and the occupancy width helper.
- Sub-module cmd_ch_fifo implements one channel: depth ENT_NUM, push/pop/flush inputs, data, cnt, full and empty outputs. It is instantiated CH_NUM times in a generate loop.
- The top level holds the strobe merge, channel decode, hang register, and done/drop registers.

## Test plan
- Single write: region=CMD, addr selects ch 2, data 0xA5A5_0001, strb=0xF -> out_vld[2] high next cycle, out_data ch2=0xA5A5_0001, fifo_wr_done pulses with ch=2.
- Strobe: data 0x1122_3344, strb=0x5 -> stored word 0x0022_0044.
- Full and park: 4 writes to ch 0 with out_rdy=0, then a 5th -> axi_wr_rdy=0. Pulse out_rdy[0] one cycle -> parked beat pushed, fifo_wr_done ch=0 two cycles after the pop, axi_wr_rdy back to 1.
- Channel independence: ch 1 full with a parked beat while ch 3 is drained continuously -> ch 3 traffic unaffected, and new AXI beats are stalled until the ch 1 beat lands.
- Flush: parked beat for ch 1, assert ch_flush[1] -> fifo_wr_drop pulses, ch_cnt[1]=0, axi_wr_rdy=1, no fifo_wr_done.
- Wrap and simultaneous traffic: 3 entries in, then 20 cycles of simultaneous push and pop on ch 0 -> FIFO order preserved and cnt stays 3. A write with region≠CMD produces no change.

Source files
------------

// File: rtl/cmd_buff_pkg.sv
// Shared definitions for the multi-channel command buffer.
//   AXI_CMD_FIFO_REGION : region code of beats the buffer accepts
//   addr_to_ch()        : extracts the channel index field from a write address
//   occ_width()         : bit width of a per-channel occupancy count
package cmd_buff_pkg;

  localparam logic [1:0] AXI_CMD_FIFO_REGION = 2'd1;

  function automatic int unsigned addr_to_ch(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned ch_bits);
    logic [63:0] mask;
    mask = (64'd1 << ch_bits) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

  // One extra bit so that full (== ENT_NUM) and empty (== 0) are distinct.
  function automatic int unsigned occ_width(input int unsigned ent);
    return $clog2(ent) + 1;
  endfunction

endpackage

// File: rtl/cmd_ch_fifo.sv
// One channel FIFO of the command buffer.
//   push/push_data : write an entry (ignored when full or flushing)
//   pop            : drop the head entry (ignored when empty or flushing)
//   flush          : clear pointers and count on the next edge
//   head_data      : head entry, zero while empty
//   cnt/full/empty : occupancy from registered state
module cmd_ch_fifo #(
  parameter int W       = 32,
  parameter int ENT_NUM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(ENT_NUM):0]   cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(ENT_NUM);

  logic [W-1:0]  mem [ENT_NUM];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (PW+1)'(ENT_NUM));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: head_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cmd_buff_mc.sv
// Multi-channel command buffer. Steers AXI command-region write beats by
// address into CH_NUM channel FIFOs; a beat hitting a full channel is parked
// in a single hang register, which stalls the AXI side until it lands.
//   axi_wr_*     : AXI slave write beat (vld/rdy/addr/data/strb/region)
//   ch_flush     : per-channel synchronous flush
//   fifo_wr_done : pulse, a beat was committed (fifo_wr_ch = its channel)
//   fifo_wr_drop : pulse, a parked beat was discarded by flush
//   out_vld/out_data/out_rdy : per-channel drain ports
//   ch_cnt       : per-channel occupancy
module cmd_buff_mc
  import cmd_buff_pkg::*;
#(
  parameter int WDATA_WIDTH  = 32,
  parameter int AWADDR_WIDTH = 32,
  parameter int CH_NUM       = 4,
  parameter int ENT_NUM      = 4,
  parameter int CH_SEL_LSB   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      axi_wr_vld,
  output logic                                      axi_wr_rdy,
  input  logic [AWADDR_WIDTH-1:0]                   axi_wr_addr,
  input  logic [WDATA_WIDTH-1:0]                    axi_wr_data,
  input  logic [WDATA_WIDTH/8-1:0]                  axi_wr_strb,
  input  logic [1:0]                                axi_wr_region,
  input  logic [CH_NUM-1:0]                         ch_flush,
  output logic                                      fifo_wr_done,
  output logic [$clog2(CH_NUM)-1:0]                 fifo_wr_ch,
  output logic                                      fifo_wr_drop,
  output logic [CH_NUM-1:0]                         out_vld,
  output logic [CH_NUM*WDATA_WIDTH-1:0]             out_data,
  input  logic [CH_NUM-1:0]                         out_rdy,
  output logic [CH_NUM*($clog2(ENT_NUM)+1)-1:0]     ch_cnt
);

  localparam int CHW = $clog2(CH_NUM);
  localparam int CW  = occ_width(ENT_NUM);

  logic [WDATA_WIDTH-1:0] wr_data_m;
  logic [CHW-1:0]         wr_ch;
  logic                   wr_q;

  logic                   hang_vld;
  logic [CHW-1:0]         hang_ch;
  logic [WDATA_WIDTH-1:0] hang_data;

  logic                   push_en;
  logic [CHW-1:0]         push_ch;
  logic [WDATA_WIDTH-1:0] push_word;
  logic                   park;
  logic                   hang_drop;
  logic                   commit;

  logic [CH_NUM-1:0]      full;
  logic [CH_NUM-1:0]      empty;

  always_comb begin
    wr_data_m = '0;
    for (int b = 0; b < WDATA_WIDTH/8; b++) begin
      if (axi_wr_strb[b]) wr_data_m[b*8 +: 8] = axi_wr_data[b*8 +: 8];
    end
  end

  assign wr_ch      = CHW'(addr_to_ch(64'(axi_wr_addr), CH_SEL_LSB, CHW));
  assign axi_wr_rdy = ~hang_vld;
  assign wr_q       = axi_wr_vld & axi_wr_rdy & (axi_wr_region == AXI_CMD_FIFO_REGION);

  // A parked beat owns the single push slot; new beats cannot arrive then
  // because axi_wr_rdy is low, so the two sources never compete.
  always_comb begin
    push_en   = 1'b0;
    push_ch   = wr_ch;
    push_word = wr_data_m;
    park      = 1'b0;
    hang_drop = 1'b0;
    if (hang_vld) begin
      push_ch   = hang_ch;
      push_word = hang_data;
      if (ch_flush[hang_ch])   hang_drop = 1'b1;
      else if (!full[hang_ch]) push_en   = 1'b1;
    end else if (wr_q) begin
      if (full[wr_ch]) park    = 1'b1;
      else             push_en = 1'b1;
    end
  end

  // A direct push into a channel being flushed is discarded by the FIFO,
  // so it is not reported as committed.
  assign commit = push_en & ~ch_flush[push_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_vld  <= 1'b0;
      hang_ch   <= '0;
      hang_data <= '0;
    end else if (hang_vld) begin
      if (hang_drop || push_en) hang_vld <= 1'b0;
    end else if (park) begin
      hang_vld  <= 1'b1;
      hang_ch   <= wr_ch;
      hang_data <= wr_data_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_done <= 1'b0;
      fifo_wr_ch   <= '0;
      fifo_wr_drop <= 1'b0;
    end else begin
      fifo_wr_done <= commit;
      fifo_wr_drop <= hang_drop;
      if (commit) fifo_wr_ch <= push_ch;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    cmd_ch_fifo #(
      .W       (WDATA_WIDTH),
      .ENT_NUM (ENT_NUM)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en & (push_ch == CHW'(i))),
      .push_data (push_word),
      .pop       (out_rdy[i]),
      .flush     (ch_flush[i]),
      .head_data (out_data[i*WDATA_WIDTH +: WDATA_WIDTH]),
      .cnt       (ch_cnt[i*CW +: CW]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign out_vld = ~empty;

endmodule

// File: tb/tb_cmd_buff_mc.sv
module tb_cmd_buff_mc;

  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int ENT = 4;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              axi_wr_vld = 1'b0;
  logic              axi_wr_rdy;
  logic [31:0]       axi_wr_addr = '0;
  logic [W-1:0]      axi_wr_data = '0;
  logic [W/8-1:0]    axi_wr_strb = '0;
  logic [1:0]        axi_wr_region = '0;
  logic [CH-1:0]     ch_flush = '0;
  logic              fifo_wr_done;
  logic [1:0]        fifo_wr_ch;
  logic              fifo_wr_drop;
  logic [CH-1:0]     out_vld;
  logic [CH*W-1:0]   out_data;
  logic [CH-1:0]     out_rdy = '0;
  logic [CH*CW-1:0]  ch_cnt;

  cmd_buff_mc #(
    .WDATA_WIDTH (W), .AWADDR_WIDTH (32), .CH_NUM (CH), .ENT_NUM (ENT), .CH_SEL_LSB (4)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .axi_wr_vld (axi_wr_vld), .axi_wr_rdy (axi_wr_rdy), .axi_wr_addr (axi_wr_addr),
    .axi_wr_data (axi_wr_data), .axi_wr_strb (axi_wr_strb), .axi_wr_region (axi_wr_region),
    .ch_flush (ch_flush), .fifo_wr_done (fifo_wr_done), .fifo_wr_ch (fifo_wr_ch),
    .fifo_wr_drop (fifo_wr_drop), .out_vld (out_vld), .out_data (out_data),
    .out_rdy (out_rdy), .ch_cnt (ch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH*CW-1:0] cnt;
    logic [CH-1:0]    vld;
    logic [CH*W-1:0]  head;
    logic             rdy;
    logic             done;
    logic [1:0]       dch;
    logic             drop;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mq[CH][$];
  bit          m_hv = 0;
  int          m_hch = 0;
  logic [31:0] m_hdata = '0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Reference model: apply one clock edge's worth of the buffer rules to the
  // queues, then queue up what the outputs must show after that edge.
  task automatic step();
    exp_t e;
    int   sz[CH];
    int   ch;
    bit   wq;
    e = '0;
    for (int c = 0; c < CH; c++) sz[c] = mq[c].size();
    ch = int'((axi_wr_addr >> 4) & 32'h3);
    wq = axi_wr_vld && !m_hv && (axi_wr_region == 2'd1);
    for (int c = 0; c < CH; c++)
      if (out_rdy[c] && sz[c] > 0 && !ch_flush[c]) void'(mq[c].pop_front());
    if (m_hv) begin
      if (ch_flush[m_hch]) begin
        e.drop = 1; m_hv = 0;
      end else if (sz[m_hch] < ENT) begin
        mq[m_hch].push_back(m_hdata);
        e.done = 1; e.dch = 2'(m_hch); m_hv = 0;
      end
    end else if (wq) begin
      if (sz[ch] == ENT) begin
        m_hv = 1; m_hch = ch; m_hdata = merge(axi_wr_data, axi_wr_strb);
      end else if (!ch_flush[ch]) begin
        mq[ch].push_back(merge(axi_wr_data, axi_wr_strb));
        e.done = 1; e.dch = 2'(ch);
      end
    end
    for (int c = 0; c < CH; c++) if (ch_flush[c]) mq[c].delete();
    for (int c = 0; c < CH; c++) begin
      e.cnt[c*CW +: CW] = CW'(mq[c].size());
      e.vld[c] = (mq[c].size() > 0);
      if (mq[c].size() > 0) e.head[c*W +: W] = mq[c][0];
    end
    e.rdy = !m_hv;
    @(posedge clk);
    #1;
    expq.push_back(e);
  endtask

  // Monitor: each expectation is compared against the DUT after its edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ch_cnt", 128'(ch_cnt), 128'(e.cnt));
        chk("out_vld", 128'(out_vld), 128'(e.vld));
        for (int c = 0; c < CH; c++)
          if (e.vld[c]) chk($sformatf("out_data[%0d]", c), 128'(out_data[c*W +: W]), 128'(e.head[c*W +: W]));
        chk("axi_wr_rdy", 128'(axi_wr_rdy), 128'(e.rdy));
        chk("fifo_wr_done", 128'(fifo_wr_done), 128'(e.done));
        if (e.done) chk("fifo_wr_ch", 128'(fifo_wr_ch), 128'(e.dch));
        chk("fifo_wr_drop", 128'(fifo_wr_drop), 128'(e.drop));
      end
    end
  end

  task automatic drive(input bit v, input int ch, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] reg_, input logic [3:0] rdy, input logic [3:0] fl);
    axi_wr_vld    = v;
    axi_wr_addr   = ($urandom & ~32'h30) | (32'(ch) << 4);
    axi_wr_data   = d;
    axi_wr_strb   = s;
    axi_wr_region = reg_;
    out_rdy       = rdy;
    ch_flush      = fl;
    step();
  endtask

  task automatic idle(input int n, input logic [3:0] rdy);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 2'd1, rdy, '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 128'(axi_wr_rdy), 128'(1));
    chk({tag, "_vld"}, 128'(out_vld), 128'(0));
    chk({tag, "_data"}, 128'(out_data), 128'(0));
    chk({tag, "_cnt"}, 128'(ch_cnt), 128'(0));
    chk({tag, "_done"}, 128'(fifo_wr_done), 128'(0));
    chk({tag, "_ch"}, 128'(fifo_wr_ch), 128'(0));
    chk({tag, "_drop"}, 128'(fifo_wr_drop), 128'(0));
  endtask

  task automatic random_phase(input int n, input int rdy_pct, input int fl_permille);
    logic [3:0] r, f;
    logic [1:0] rg;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) begin
        r[c] = ($urandom_range(99) < rdy_pct);
        f[c] = ($urandom_range(999) < fl_permille);
      end
      rg = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'd1;
      drive($urandom_range(3) != 0, $urandom_range(3), $urandom, 4'($urandom), rg, r, f);
    end
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write to ch 2, then a strobed write to ch 3
    drive(1, 2, 32'hA5A5_0001, 4'hF, 2'd1, 4'h0, 4'h0);
    drive(1, 3, 32'h1122_3344, 4'h5, 2'd1, 4'h0, 4'h0);
    idle(1, 4'hC);
    // fill ch 0 and park a fifth beat, then free one slot
    for (int i = 0; i < 5; i++) drive(1, 0, 32'h0C00_0000 + i, 4'hF, 2'd1, 4'h0, 4'h0);
    idle(2, 4'h0);
    idle(1, 4'h1);
    idle(3, 4'h0);
    // ch 1 full with a parked beat while ch 3 drains; then flush ch 1
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h1100_0000 + i, 4'hF, 2'd1, 4'h8, 4'h0);
    drive(1, 1, 32'h1100_00FF, 4'hF, 2'd1, 4'h8, 4'h0);
    drive(1, 3, 32'h3300_0000, 4'hF, 2'd1, 4'h8, 4'h0);
    drive(1, 3, 32'h3300_0001, 4'hF, 2'd1, 4'h8, 4'h0);
    drive(0, 0, '0, '0, 2'd1, 4'h8, 4'h2);
    idle(2, 4'h0);
    drive(0, 0, '0, '0, 2'd1, 4'h0, 4'hF);
    // wrap with simultaneous push/pop on ch 0, plus an off-region beat
    for (int i = 0; i < 3; i++) drive(1, 0, 32'hAA00_0000 + i, 4'hF, 2'd1, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) drive(1, 0, 32'hBB00_0000 + i, 4'hF, 2'd1, 4'h1, 4'h0);
    drive(1, 0, 32'hDEAD_BEEF, 4'hF, 2'd2, 4'h0, 4'h0);
    drive(0, 0, '0, '0, 2'd1, 4'h0, 4'hF);

    random_phase(1500, 20, 10);
    random_phase(1500, 55, 20);
    random_phase(1500, 90, 5);
    random_phase(300, 10, 0);

    // asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    axi_wr_vld = 1'b0; out_rdy = '0; ch_flush = '0;
    #1 check_zero("mid_reset");
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_hv = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    random_phase(300, 50, 10);
    idle(2, 4'h0);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
